// File: rtl/arb_mux.sv
// N-input arbitrating multiplexer with a one-entry registered output stage.
// The grant comes from a round-robin or fixed-priority arbiter.
module arb_mux #(
  parameter int WIDTH = 32,
  parameter int N     = 4,
  parameter int RR    = 1,
  parameter int SELW  = (N > 1) ? $clog2(N) : 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [N-1:0]         in_valid,
  input  logic [N*WIDTH-1:0]   in_data,
  output logic [N-1:0]         in_ready,
  output logic                 out_valid,
  output logic [WIDTH-1:0]     out_data,
  output logic [SELW-1:0]      out_sel,
  input  logic                 out_ready
);

  logic             vld_p0;
  logic [WIDTH-1:0] data_p0;
  logic [SELW-1:0]  sel_p0;
  logic [SELW-1:0]  ptr;
  logic [SELW-1:0]  grant;
  logic [SELW-1:0]  idx;
  logic             any_valid;
  logic             load;
  int               j;

  // Stage 0 input: arbitration, searching upward from ptr with wrap-around
  always_comb begin
    grant     = '0;
    any_valid = 1'b0;
    idx       = '0;
    j         = 0;
    for (int k = 0; k < N; k++) begin
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      idx = SELW'(j);
      if (!any_valid && in_valid[idx]) begin
        grant     = idx;
        any_valid = 1'b1;
      end
    end
  end

  assign load     = !vld_p0 || out_ready;
  assign in_ready = (load && any_valid) ? (N'(1) << grant) : '0;

  // Stage 0 register: the held beat
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_p0  <= 1'b0;
      data_p0 <= '0;
      sel_p0  <= '0;
    end else if (load) begin
      vld_p0 <= any_valid;
      if (any_valid) begin
        data_p0 <= in_data[grant*WIDTH +: WIDTH];
        sel_p0  <= grant;
      end
    end
  end

  generate
    if (RR != 0) begin : g_rr
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
          ptr <= '0;
        else if (load && any_valid)
          ptr <= (int'(grant) == N - 1) ? '0 : grant + 1'b1;
      end
    end else begin : g_fp
      assign ptr = '0;
    end
  endgenerate

  assign out_valid = vld_p0;
  assign out_data  = data_p0;
  assign out_sel   = sel_p0;

endmodule

// File: tb/tb_arb_mux.sv
// Scoreboard bench for arb_mux: one round-robin and one fixed-priority instance
// share the same inputs and are each checked against a spec-level model.
module tb_arb_mux;
  localparam int W = 32;
  localparam int N = 4;

  typedef struct {
    logic [W-1:0] d;
    int           s;
  } beat_t;

  logic           clk = 1'b0;
  logic           reset_n = 1'b0;
  logic [N-1:0]   in_valid = '0;
  logic [N*W-1:0] in_data = '0;
  logic           out_ready = 1'b0;

  logic [N-1:0]   rdy [2];
  logic           ov  [2];
  logic [W-1:0]   od  [2];
  logic [1:0]     os  [2];

  int vectors = 0;
  int miscompares = 0;

  // model state: index 0 = round-robin instance, 1 = fixed priority
  logic  mv   [2];
  int    mptr [2];
  beat_t q    [2][$];

  always #5 clk = ~clk;

  arb_mux #(.WIDTH(W), .N(N), .RR(1)) u_rr (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(rdy[0]), .out_valid(ov[0]), .out_data(od[0]), .out_sel(os[0]),
    .out_ready(out_ready));

  arb_mux #(.WIDTH(W), .N(N), .RR(0)) u_fp (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(rdy[1]), .out_valid(ov[1]), .out_data(od[1]), .out_sel(os[1]),
    .out_ready(out_ready));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int model_grant(input int m, input logic [N-1:0] v, input int p);
    int start;
    start = (m == 0) ? p : 0;
    for (int k = 0; k < N; k++)
      if (v[(start + k) % N]) return (start + k) % N;
    return -1;
  endfunction

  // reference model: advances on each rising edge, pushes accepted beats
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int m = 0; m < 2; m++) begin
        mv[m] = 1'b0;
        mptr[m] = 0;
        q[m].delete();
      end
    end else begin
      for (int m = 0; m < 2; m++) begin
        int g;
        beat_t b;
        g = model_grant(m, in_valid, mptr[m]);
        if (!mv[m] || out_ready) begin
          if (g >= 0) begin
            b.d = in_data[g*W +: W];
            b.s = g;
            q[m].push_back(b);
            mv[m] = 1'b1;
            if (m == 0) mptr[m] = (g + 1) % N;
          end else begin
            mv[m] = 1'b0;
          end
        end
      end
    end
  end

  // monitor: samples on the falling edge, pops beats as the consumer takes them
  always @(negedge clk) begin
    if (reset_n) begin
      for (int m = 0; m < 2; m++) begin
        int g;
        logic [N-1:0] er;
        string tag;
        tag = (m == 0) ? "rr" : "fp";
        g = model_grant(m, in_valid, mptr[m]);
        er = (g >= 0 && (!mv[m] || out_ready)) ? (N'(1) << g) : '0;
        check({tag, "_in_ready"}, 64'(rdy[m]), 64'(er));
        check({tag, "_out_valid"}, 64'(ov[m]), 64'(mv[m]));
        if (mv[m]) begin
          if (q[m].size() == 0) begin
            check({tag, "_queue_empty"}, 64'(1), 64'(0));
          end else begin
            check({tag, "_out_data"}, 64'(od[m]), 64'(q[m][0].d));
            check({tag, "_out_sel"}, 64'(os[m]), 64'(q[m][0].s));
            if (out_ready) void'(q[m].pop_front());
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mid_reset();
    @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    for (int m = 0; m < 2; m++) begin
      check("rst_out_valid", 64'(ov[m]), 64'(0));
      check("rst_out_data", 64'(od[m]), 64'(0));
      check("rst_out_sel", 64'(os[m]), 64'(0));
    end
    @(posedge clk);
    #2 reset_n = 1'b1;
  endtask

  task automatic set_ch(input int i, input logic [W-1:0] d);
    in_data[i*W +: W] = d;
  endtask

  initial begin
    repeat (2) step();
    reset_n = 1'b1;
    step();
    mid_reset();
    in_valid = '0;
    out_ready = 1'b1;
    repeat (2) step();

    // single channel
    in_valid = 4'b0100;
    set_ch(2, 32'hABCDEF01);
    step();
    in_valid = '0;
    step();

    // all channels valid, round-robin wrap
    for (int i = 0; i < N; i++) set_ch(i, W'(i));
    in_valid = 4'b1111;
    repeat (8) step();

    // backpressure
    for (int i = 0; i < N; i++) set_ch(i, 32'h00400004 + W'(i << 8));
    step();
    out_ready = 1'b0;
    repeat (3) step();
    out_ready = 1'b1;
    repeat (2) step();

    // fixed priority pattern, then drop channel 1
    in_valid = 4'b1010;
    repeat (4) step();
    in_valid = 4'b1000;
    repeat (2) step();
    in_valid = '0;
    step();

    // advance round-robin pointer to 2, hold a beat, reset mid-stream
    in_valid = 4'b0010;
    step();
    in_valid = 4'b1111;
    out_ready = 1'b0;
    repeat (2) step();
    mid_reset();
    out_ready = 1'b1;
    repeat (4) step();

    // randomized traffic
    for (int c = 0; c < 400; c++) begin
      in_valid = N'($urandom_range(0, 15));
      in_data = {$urandom, $urandom, $urandom, $urandom};
      out_ready = ($urandom_range(0, 9) < 7);
      step();
    end
    in_valid = '0;
    out_ready = 1'b1;
    repeat (3) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
